// File: rtl/main_memory_ctrl_pkg.sv
// Shared definitions for the main-memory controller: widths, FSM state and client encodings.
package main_memory_ctrl_pkg;

   localparam int ARCH_BITS        = 32;
   localparam int MEMORY_LINE_BITS = 128;

   typedef enum logic [1:0] {
      MEM_IDLE = 2'd0,
      MEM_BUSY = 2'd1,
      MEM_RESP = 2'd2
   } mem_state_e;

   typedef enum logic [1:0] {
      CLIENT_IREAD  = 2'd0,
      CLIENT_DREAD  = 2'd1,
      CLIENT_DWRITE = 2'd2
   } client_e;

endpackage

// File: rtl/main_memory_ctrl_mem_line_array.sv
// Line-wide backing store: synchronous write port, registered read port, no reset on contents.
module main_memory_ctrl_mem_line_array
   import main_memory_ctrl_pkg::*;
#(
   parameter int LINES    = 256,
   parameter int WIDTH    = MEMORY_LINE_BITS,
   parameter int IDX_BITS = $clog2(LINES)
) (
   input  logic                clk,
   input  logic                we_i,
   input  logic [IDX_BITS-1:0] waddr_i,
   input  logic [WIDTH-1:0]    wdata_i,
   input  logic                re_i,
   input  logic [IDX_BITS-1:0] raddr_i,
   output logic [WIDTH-1:0]    rdata_o
);

   logic [WIDTH-1:0] mem_q [LINES];
   logic [WIDTH-1:0] rdata_q;

   // Store write port
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   // Registered read port; holds between read enables
   always_ff @(posedge clk) begin
      if (re_i) begin
         rdata_q <= mem_q[raddr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/main_memory_ctrl.sv
// Main-memory controller: arbitrates cache refills/writebacks onto one line store with fixed latency.
// Optional MEM_ROUND_ROBIN_EN alternates priority between the two read clients.
module main_memory_ctrl
   import main_memory_ctrl_pkg::*;
#(
   parameter int MEM_LINES        = 256,
   parameter int LATENCY          = 4,
   parameter int LINE_OFFSET_BITS = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        iReadReq,
   input  logic [ARCH_BITS-1:0]        iReadAddr,
   output logic [MEMORY_LINE_BITS-1:0] iReadData,
   output logic                        iReadValid,
   input  logic                        dReadReq,
   input  logic [ARCH_BITS-1:0]        dReadAddr,
   output logic [MEMORY_LINE_BITS-1:0] dReadData,
   output logic                        dReadValid,
   input  logic                        dWriteReq,
   input  logic [ARCH_BITS-1:0]        dWriteAddr,
   input  logic [MEMORY_LINE_BITS-1:0] dWriteLine,
   output logic                        dWriteAck,
   output logic                        busy
);

   localparam int IDX_BITS = $clog2(MEM_LINES);
   localparam int CNT_BITS = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam logic [CNT_BITS-1:0] CNT_LOAD = CNT_BITS'(LATENCY - 1);

   mem_state_e                  state_q, state_d;
   client_e                     client_q, client_d, grant_client_s;
   logic [IDX_BITS-1:0]         idx_q, idx_d, grant_idx_s;
   logic [MEMORY_LINE_BITS-1:0] wdata_q, wdata_d;
   logic [CNT_BITS-1:0]         cnt_q, cnt_d;
   logic [ARCH_BITS-1:0]        grant_addr_s;
   logic                        grant_s, d_first_s, rd_req_s;
   logic                        mem_we_s, mem_re_s;
   logic [MEMORY_LINE_BITS-1:0] mem_rdata_s;
   logic                        i_valid_q, i_valid_d, d_valid_q, d_valid_d, w_ack_q, w_ack_d;
   logic                        busy_q, busy_d;
   logic [MEMORY_LINE_BITS-1:0] i_data_q, i_data_d, d_data_q, d_data_d;
   logic                        unused_addr_s;

`ifdef MEM_ROUND_ROBIN_EN
   logic last_i_q;

   // Last-served read pointer; starts at iRead so dRead wins the first tie
   always_ff @(posedge clk) begin
      if (rst) begin
         last_i_q <= 1'b1;
      end else if (state_q == MEM_IDLE && grant_s && grant_client_s != CLIENT_DWRITE) begin
         last_i_q <= (grant_client_s == CLIENT_IREAD);
      end else begin
         last_i_q <= last_i_q;
      end
   end

   assign d_first_s = last_i_q;
`else
   assign d_first_s = 1'b1;
`endif

   // Request arbiter: dWrite always first, then reads by priority
   always_comb begin
      grant_s        = 1'b0;
      grant_client_s = CLIENT_DWRITE;
      grant_addr_s   = dWriteAddr;
      if (dWriteReq) begin
         grant_s = 1'b1;
      end else if (dReadReq && (!iReadReq || d_first_s)) begin
         grant_s        = 1'b1;
         grant_client_s = CLIENT_DREAD;
         grant_addr_s   = dReadAddr;
      end else if (iReadReq) begin
         grant_s        = 1'b1;
         grant_client_s = CLIENT_IREAD;
         grant_addr_s   = iReadAddr;
      end else begin
         grant_s = 1'b0;
      end
   end

   assign grant_idx_s   = grant_addr_s[LINE_OFFSET_BITS +: IDX_BITS];
   assign rd_req_s      = (client_q == CLIENT_IREAD) ? iReadReq : dReadReq;
   assign unused_addr_s = ^{iReadAddr, dReadAddr, dWriteAddr};

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= MEM_IDLE;
         client_q  <= CLIENT_DWRITE;
         idx_q     <= '0;
         wdata_q   <= '0;
         cnt_q     <= '0;
         i_valid_q <= 1'b0;
         d_valid_q <= 1'b0;
         w_ack_q   <= 1'b0;
         busy_q    <= 1'b0;
         i_data_q  <= '0;
         d_data_q  <= '0;
      end else begin
         state_q   <= state_d;
         client_q  <= client_d;
         idx_q     <= idx_d;
         wdata_q   <= wdata_d;
         cnt_q     <= cnt_d;
         i_valid_q <= i_valid_d;
         d_valid_q <= d_valid_d;
         w_ack_q   <= w_ack_d;
         busy_q    <= busy_d;
         i_data_q  <= i_data_d;
         d_data_q  <= d_data_d;
      end
   end

   // Next-state logic; a read whose requester drops out is abandoned without a response
   always_comb begin
      state_d  = state_q;
      client_d = client_q;
      idx_d    = idx_q;
      wdata_d  = wdata_q;
      cnt_d    = cnt_q;
      case (state_q)
         MEM_IDLE: begin
            if (grant_s) begin
               state_d  = MEM_BUSY;
               client_d = grant_client_s;
               idx_d    = grant_idx_s;
               wdata_d  = dWriteLine;
               cnt_d    = CNT_LOAD;
            end else begin
               state_d = MEM_IDLE;
            end
         end
         MEM_BUSY: begin
            if (client_q != CLIENT_DWRITE && !rd_req_s) begin
               state_d = MEM_IDLE;
            end else if (cnt_q == CNT_BITS'(0)) begin
               state_d = MEM_RESP;
            end else begin
               cnt_d = cnt_q - CNT_BITS'(1);
            end
         end
         MEM_RESP: state_d = MEM_IDLE;
         default:  state_d = MEM_IDLE;
      endcase
   end

   // Output and store-control logic
   always_comb begin
      mem_we_s  = 1'b0;
      mem_re_s  = 1'b0;
      i_valid_d = 1'b0;
      d_valid_d = 1'b0;
      w_ack_d   = 1'b0;
      i_data_d  = i_data_q;
      d_data_d  = d_data_q;
      busy_d    = (state_d != MEM_IDLE);
      if (state_q == MEM_IDLE && grant_s && grant_client_s != CLIENT_DWRITE) begin
         mem_re_s = ~rst;
      end else if (state_q == MEM_BUSY && state_d == MEM_RESP) begin
         case (client_q)
            CLIENT_DWRITE: begin
               mem_we_s = ~rst;
               w_ack_d  = 1'b1;
            end
            CLIENT_DREAD: begin
               d_valid_d = 1'b1;
               d_data_d  = mem_rdata_s;
            end
            CLIENT_IREAD: begin
               i_valid_d = 1'b1;
               i_data_d  = mem_rdata_s;
            end
            default: begin
               w_ack_d = 1'b0;
            end
         endcase
      end else begin
         mem_we_s = 1'b0;
      end
   end

   main_memory_ctrl_mem_line_array #(
      .LINES (MEM_LINES),
      .WIDTH (MEMORY_LINE_BITS)
   ) u_store (
      .clk     (clk),
      .we_i    (mem_we_s),
      .waddr_i (idx_q),
      .wdata_i (wdata_q),
      .re_i    (mem_re_s),
      .raddr_i (grant_idx_s),
      .rdata_o (mem_rdata_s)
   );

   assign iReadData  = i_data_q;
   assign iReadValid = i_valid_q;
   assign dReadData  = d_data_q;
   assign dReadValid = d_valid_q;
   assign dWriteAck  = w_ack_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_main_memory_ctrl.sv
// Self-checking bench for main_memory_ctrl: directed timing cases plus random traffic vs. a line-store model.
module tb_main_memory_ctrl;

   localparam int L = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic         iReadReq, dReadReq, dWriteReq;
   logic [31:0]  iReadAddr, dReadAddr, dWriteAddr;
   logic [127:0] dWriteLine, iReadData, dReadData;
   logic         iReadValid, dReadValid, dWriteAck, busy;

   int errors = 0;
   int checks = 0;

   logic [127:0] model [256];
   int           known_q [$];
   logic [127:0] last_i = 128'd0;
   logic [127:0] last_d = 128'd0;

   always #5 clk = ~clk;

   main_memory_ctrl #(.MEM_LINES(256), .LATENCY(L), .LINE_OFFSET_BITS(4)) dut (
      .clk(clk), .rst(rst),
      .iReadReq(iReadReq), .iReadAddr(iReadAddr), .iReadData(iReadData), .iReadValid(iReadValid),
      .dReadReq(dReadReq), .dReadAddr(dReadAddr), .dReadData(dReadData), .dReadValid(dReadValid),
      .dWriteReq(dWriteReq), .dWriteAddr(dWriteAddr), .dWriteLine(dWriteLine), .dWriteAck(dWriteAck),
      .busy(busy)
   );

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic int idx_of(input logic [31:0] a);
      return int'((a >> 4) & 32'd255);
   endfunction

   function automatic logic [127:0] pulses();
      return {125'd0, dWriteAck, dReadValid, iReadValid};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // n edges; quiet with held data before the nth, then exactly one pulse of 'kind'
   task automatic expect_pulse(input int kind, input int n, input logic [127:0] exp, input string tag);
      for (int k = 1; k <= n; k++) begin
         step();
         if (k < n) begin
            chk({tag, "_quiet"}, pulses(), 128'd0);
            chk({tag, "_ihold"}, iReadData, last_i);
            chk({tag, "_dhold"}, dReadData, last_d);
         end
      end
      chk({tag, "_pulse"}, pulses(), 128'd1 << kind);
      chk({tag, "_busy"}, {127'd0, busy}, 128'd1);
      if (kind == 0) begin
         chk({tag, "_idata"}, iReadData, exp);
         last_i = exp;
      end else if (kind == 1) begin
         chk({tag, "_ddata"}, dReadData, exp);
         last_d = exp;
      end
   endtask

   task automatic idle_check(input string tag);
      step();
      chk({tag, "_end"}, {126'd0, busy, |pulses()}, 128'd0);
   endtask

   task automatic model_write(input logic [31:0] a, input logic [127:0] d);
      if (!(model[idx_of(a)] !== 128'bx && known_q.size() > 0 && 1'b0)) begin
         model[idx_of(a)] = d;
      end
      known_q.push_back(idx_of(a));
   endtask

   // One isolated transaction: kind 0=iRead, 1=dRead, 2=dWrite
   task automatic run_txn(input int kind, input logic [31:0] a, input logic [127:0] d, input string tag);
      logic [127:0] exp;
      exp = (kind == 2) ? 128'd0 : model[idx_of(a)];
      case (kind)
         0:       begin iReadReq = 1'b1; iReadAddr = a; end
         1:       begin dReadReq = 1'b1; dReadAddr = a; end
         default: begin dWriteReq = 1'b1; dWriteAddr = a; dWriteLine = d; end
      endcase
      expect_pulse(kind, L + 1, exp, tag);
      iReadReq = 1'b0; dReadReq = 1'b0; dWriteReq = 1'b0;
      if (kind == 2) model_write(a, d);
      idle_check(tag);
   endtask

   function automatic logic [127:0] rnd_line();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   initial begin
      logic [127:0] d3;
      logic [31:0]  a;
      int           kind;

      rst = 1'b1;
      iReadReq = 1'b0; dReadReq = 1'b0; dWriteReq = 1'b0;
      iReadAddr = 32'd0; dReadAddr = 32'd0; dWriteAddr = 32'd0; dWriteLine = 128'd0;
      step(); step();
      chk("rst_pulses", pulses(), 128'd0);
      chk("rst_busy", {127'd0, busy}, 128'd0);
      chk("rst_idata", iReadData, 128'd0);
      chk("rst_ddata", dReadData, 128'd0);
      rst = 1'b0;

      run_txn(2, 32'h0000_0040, 128'h00112233445566778899AABBCCDDEEFF, "wr40");
      run_txn(1, 32'h0000_0040, 128'd0, "rd40");

      run_txn(2, 32'h0000_0010, 128'hCAFEF00D_DEADBEEF_01234567_89ABCDEF, "wrap_wr");
      run_txn(1, 32'h0000_1010, 128'd0, "wrap_rd");

      // Simultaneous reads: dRead served first, iRead picked up after the gap
      dReadAddr = 32'h0000_0040; iReadAddr = 32'h0000_1010;
      dReadReq = 1'b1; iReadReq = 1'b1;
      expect_pulse(1, L + 1, model[4], "tie_d");
      dReadReq = 1'b0;
      expect_pulse(0, L + 2, model[1], "tie_i");
      iReadReq = 1'b0;
      idle_check("tie");

      // Both read requests held continuously across four services
      dReadReq = 1'b1; iReadReq = 1'b1;
      for (int r = 0; r < 4; r++) begin
`ifdef MEM_ROUND_ROBIN_EN
         kind = (r % 2 == 0) ? 1 : 0;
`else
         kind = 1;
`endif
         expect_pulse(kind, (r == 0) ? L + 1 : L + 2, (kind == 1) ? model[4] : model[1], "hold");
      end
      dReadReq = 1'b0; iReadReq = 1'b0;
      idle_check("hold");

      // Eviction: writeback and refill of the same line raised together
      d3 = rnd_line();
      dWriteAddr = 32'h0005_0080; dWriteLine = d3; dReadAddr = 32'h0000_0088;
      dWriteReq = 1'b1; dReadReq = 1'b1;
      expect_pulse(2, L + 1, 128'd0, "evict_w");
      dWriteReq = 1'b0;
      model_write(32'h0000_0080, d3);
      expect_pulse(1, L + 2, d3, "evict_r");
      dReadReq = 1'b0;
      idle_check("evict");

      // Abandoned refill
      iReadAddr = 32'h0000_0080; iReadReq = 1'b1;
      step();
      chk("abandon_busy0", {127'd0, busy}, 128'd1);
      step();
      iReadReq = 1'b0;
      step();
      chk("abandon_busy2", {127'd0, busy}, 128'd0);
      for (int k = 0; k < L + 2; k++) begin
         step();
         chk("abandon_quiet", pulses(), 128'd0);
         chk("abandon_ihold", iReadData, last_i);
      end
      run_txn(0, 32'h0000_0080, 128'd0, "after_abandon");

      // Reset in the middle of a write
      dWriteAddr = 32'h0000_0040; dWriteLine = rnd_line(); dWriteReq = 1'b1;
      step(); step();
      rst = 1'b1; dWriteReq = 1'b0;
      step();
      chk("mrst_pulses", pulses(), 128'd0);
      chk("mrst_busy", {127'd0, busy}, 128'd0);
      chk("mrst_idata", iReadData, 128'd0);
      chk("mrst_ddata", dReadData, 128'd0);
      last_i = 128'd0; last_d = 128'd0;
      rst = 1'b0;
      for (int k = 0; k < L + 2; k++) begin
         step();
         chk("mrst_quiet", {126'd0, busy, |pulses()}, 128'd0);
      end
      run_txn(1, 32'h0000_0040, 128'd0, "mrst_rd");

      // Random traffic against the line-store model
      for (int t = 0; t < 40; t++) begin
         kind = $urandom_range(2);
         a = $urandom;
         if (kind != 2) a[11:4] = 8'(known_q[$urandom_range(known_q.size() - 1)]);
         run_txn(kind, a, rnd_line(), "rand");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/main_memory_ctrl.md
# main_memory_ctrl

Main-memory controller directly downstream of the instruction and data caches. It accepts line refill requests from both caches and dirty-line writebacks from the data cache. Requests are arbitrated onto a single line-wide backing store with a fixed, parameterised access latency. For each granted transaction it returns exactly one single-cycle valid/ack pulse, using the level-request / pulse-response handshake the caches already speak.

## Interface
Parameters:
- MEM_LINES, 256: number of lines in the backing store; power of two.
- LATENCY, 4: cycles spent in BUSY per access; minimum 1.
- LINE_OFFSET_BITS, 4: address bits below the line index (16-byte lines).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- iReadReq  in  1  instruction-cache refill request (level).
- iReadAddr  in  ARCH_BITS  refill byte address.
- iReadData  out  MEMORY_LINE_BITS  refill line.
- iReadValid  out  1  one-cycle pulse; iReadData is valid while it is high.
- dReadReq  in  1  data-cache refill request (level).
- dReadAddr  in  ARCH_BITS  refill byte address.
- dReadData  out  MEMORY_LINE_BITS  refill line.
- dReadValid  out  1  one-cycle pulse.
- dWriteReq  in  1  data-cache writeback request (level).
- dWriteAddr  in  ARCH_BITS  writeback byte address.
- dWriteLine  in  MEMORY_LINE_BITS  writeback line.
- dWriteAck  out  1  one-cycle pulse.
- busy  out  1  high in any state other than IDLE.

## Operation
- Line index = addr[LINE_OFFSET_BITS +: log2(MEM_LINES)]. Upper address bits are ignored, so addresses wrap modulo the store size.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - Samples requests at each edge.
  - Priority: dWrite > dRead > iRead (fixed; see Configuration).
  - On a grant, latch client id, line index and write data; load counter = LATENCY-1; go to BUSY.
- BUSY:
  - Counter decrements each cycle.
  - When the counter is 0, go to RESP. A granted write commits the line to the store at this edge. A granted read latches the store line into the output register at this edge.
- RESP: the granted client's valid/ack is high for exactly one cycle; then go to IDLE.
- Read abandonment: if a granted read client's req is low at any BUSY edge, go directly to IDLE. No pulse is issued and the store is unchanged.
- Writes are never abandoned; the write data latched at grant is committed.
- Read data outputs hold their last value outside RESP. Valid/ack outputs are 0 outside RESP.
- A write followed by a read of the same line returns the written data.
- Reset:
  - All outputs go to 0 and the FSM goes to IDLE.
  - An in-flight transaction is dropped with no pulse.
  - Store contents are not reset.

## Timing
- A request sampled at edge t produces a response pulse in the cycle after edge t+LATENCY, deasserted at edge t+LATENCY+1.
- Earliest next grant is at edge t+LATENCY+2. This gap guarantees that a request still high while the cache consumes the pulse is not re-granted.
- Back-to-back transactions therefore take LATENCY+2 cycles each.
- Simultaneous requests: exactly one grant per IDLE edge. Losing requests stay pending (level) and are served later.
- A data-cache eviction (dWriteReq together with dReadReq) always completes the write before the refill.

## Configuration
- MEM_ROUND_ROBIN_EN defined: the two read clients alternate priority using a last-served read pointer. The pointer resets to iRead, so dRead wins the first tie. dWrite keeps top priority.
- MEM_ROUND_ROBIN_EN undefined: fixed priority dRead > iRead; no pointer register.

## Structure
- Shared proc package carries ARCH_BITS, MEMORY_LINE_BITS, the MEM_IDLE/MEM_BUSY/MEM_RESP state encodings, and the client-id encodings.
- One sub-module, mem_line_array: MEM_LINES x MEMORY_LINE_BITS storage with a synchronous write port and a registered read port. It has no reset.
- The FSM, arbiter and counter live in main_memory_ctrl.

## Test plan
- Write then read, LATENCY=4:
  - dWriteReq, addr 0x40, line 0x11..FF, sampled at edge 0 -> dWriteAck high in the cycle after edge 4 only.
  - dReadReq addr 0x40 at edge 6 -> dReadValid after edge 10 with the same line.
- Wrap-around: write to 0x00000010, read from 0x00001010 (MEM_LINES=256) -> same line returned.
- Tie, fixed priority: dReadReq and iReadReq both raised before edge 0 -> dRead is served first (pulse after edge 4); iRead is granted at edge 6 (pulse after edge 10).
  - With MEM_ROUND_ROBIN_EN, repeated ties alternate d, i, d, i.
- Eviction: dWriteReq and dReadReq on the same index -> dWriteAck precedes dReadValid, and the read returns the newly written line.
- Abandon: iReadReq granted at edge 0, dropped before edge 2 -> no iReadValid, busy low by edge 3.
- Reset mid-write: rst at edge 2 of a write -> no ack, all outputs 0, FSM in IDLE; a subsequent read returns the prior contents.
